// File: rtl/wisc_pkg.sv
// wisc_pkg -- shared WISC definitions.
// Holds the default datapath/register-index widths, the 4-bit opcode
// constants, and the flag-class helpers used by the EX/MEM result stage
// and by decode's hazard logic.
package wisc_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int RW_DEFAULT = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    // Opcodes that write V and N (arithmetic with a meaningful sign/overflow).
    function automatic logic sets_nv(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Opcodes that write Z (arithmetic plus logic/shift class).
    function automatic logic sets_z(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if -- EX-side bundle presented to the result stage.
// Signals: in_valid, in_op, in_result (DW), in_ovfl, in_dst (RW), in_wr_en.
// master: the execute stage driving the bundle; slave: the result stage.
interface alu_result_stage_if #(
    parameter int DW = wisc_pkg::DW_DEFAULT,
    parameter int RW = wisc_pkg::RW_DEFAULT
);
    logic          in_valid;
    logic [3:0]    in_op;
    logic [DW-1:0] in_result;
    logic          in_ovfl;
    logic [RW-1:0] in_dst;
    logic          in_wr_en;

    modport master (
        output in_valid, in_op, in_result, in_ovfl, in_dst, in_wr_en
    );

    modport slave (
        input in_valid, in_op, in_result, in_ovfl, in_dst, in_wr_en
    );
endinterface

// File: rtl/alu_result_stage_flag_reg.sv
// alu_result_stage_flag_reg -- architectural Z/V/N flag storage.
// Ports: clk, rst_n (async active-low), z_en/v_en/n_en per-flag write
// enables, z_d/v_d/n_d next values, flag_z/flag_v/flag_n stored flags.
module alu_result_stage_flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic z_en,
    input  logic v_en,
    input  logic n_en,
    input  logic z_d,
    input  logic v_d,
    input  logic n_d,
    output logic flag_z,
    output logic flag_v,
    output logic flag_n
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (z_en) flag_z <= z_d;
            if (v_en) flag_v <= v_d;
            if (n_en) flag_n <= n_d;
        end
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage -- EX/MEM pipeline boundary for the WISC core.
// Ports: clk, rst_n (async active-low), ex (slave bundle from the ALU),
// stall (hold), flush (insert bubble), out_valid/out_op/out_result/
// out_dst/out_wr_en (captured instruction), flag_z/flag_v/flag_n
// (architectural flags), halted (sticky after HLT is accepted).
module alu_result_stage
    import wisc_pkg::*;
#(
    parameter int DW = wisc_pkg::DW_DEFAULT,
    parameter int RW = wisc_pkg::RW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_result_stage_if.slave     ex,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [3:0]            out_op,
    output logic [DW-1:0]         out_result,
    output logic [RW-1:0]         out_dst,
    output logic                  out_wr_en,
    output logic                  flag_z,
    output logic                  flag_v,
    output logic                  flag_n,
    output logic                  halted
);
    logic          accept;
    logic          valid_p1;
    logic [3:0]    op_p1;
    logic [DW-1:0] result_p1;
    logic [RW-1:0] dst_p1;
    logic          wr_en_p1;
    logic          halted_p1;

    assign accept = ex.in_valid && !stall && !flush && !halted_p1;

    // EX -> MEM boundary: flush beats stall; a halted stage holds its HLT
    // until flushed, and only reset releases the halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p1  <= 1'b0;
            op_p1     <= 4'd0;
            result_p1 <= '0;
            dst_p1    <= '0;
            wr_en_p1  <= 1'b0;
            halted_p1 <= 1'b0;
        end else if (flush) begin
            valid_p1  <= 1'b0;
            op_p1     <= 4'd0;
            result_p1 <= '0;
            dst_p1    <= '0;
            wr_en_p1  <= 1'b0;
        end else if (!stall && !halted_p1) begin
            if (ex.in_valid) begin
                valid_p1  <= 1'b1;
                op_p1     <= ex.in_op;
                result_p1 <= ex.in_result;
                dst_p1    <= ex.in_dst;
                // HLT never writes the register file even if decode said so.
                wr_en_p1  <= ex.in_wr_en && (ex.in_op != OP_HLT);
                if (ex.in_op == OP_HLT) halted_p1 <= 1'b1;
            end else begin
                valid_p1  <= 1'b0;
                op_p1     <= 4'd0;
                result_p1 <= '0;
                dst_p1    <= '0;
                wr_en_p1  <= 1'b0;
            end
        end
    end

    // Z is taken from the saturated result, so a clamped overflow never
    // reads as zero.
    alu_result_stage_flag_reg u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .z_en   (accept && sets_z(ex.in_op)),
        .v_en   (accept && sets_nv(ex.in_op)),
        .n_en   (accept && sets_nv(ex.in_op)),
        .z_d    (ex.in_result == '0),
        .v_d    (ex.in_ovfl),
        .n_d    (ex.in_result[DW-1]),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n)
    );

    assign out_valid  = valid_p1;
    assign out_op     = op_p1;
    assign out_result = result_p1;
    assign out_dst    = dst_p1;
    assign out_wr_en  = wr_en_p1 && valid_p1;
    assign halted     = halted_p1;
endmodule
